// File: rtl/vga_capture_ctrl.sv
// Avalon-MM slave that arms on software start, waits for a VGA frame boundary and
// captures one rectangular pixel window into an on-chip FIFO for HPS readout.
module vga_capture_ctrl #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned XW         = 11,
  parameter int unsigned YW         = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  input  logic        HSYNC,
  input  logic        VSYNC,
  input  logic        pix_en,
  output logic        busy,
  output logic        irq
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = XW + YW;

  localparam logic [7:0] ADDR_CTRL   = 8'd0;
  localparam logic [7:0] ADDR_STATUS = 8'd1;
  localparam logic [7:0] ADDR_WIN_X  = 8'd2;
  localparam logic [7:0] ADDR_WIN_Y  = 8'd3;
  localparam logic [7:0] ADDR_DATA   = 8'd4;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t            state;
  logic [XW-1:0]     x_cnt, win_x0, win_w;
  logic [YW-1:0]     y_cnt, win_y0, win_h;
  logic              hsync_q, vsync_q;
  logic [23:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic              done, overflow;
  logic [CW-1:0]     cap_cnt, cap_target;

  logic              ctrl_wr, start_cmd, abort_cmd, win_wr_ok;
  logic              frame_start, frame_end;
  logic [XW:0]       x_hi;
  logic [YW:0]       y_hi;
  logic              x_in, y_in, in_win, capturing;
  logic              pop, push, fifo_full, flush, last_pix;
  logic              unused_wdata;

  assign unused_wdata = ^writedata;

  // Bus command and raster window decode
  always_comb begin
    ctrl_wr     = chipselect && write && (address == ADDR_CTRL);
    abort_cmd   = ctrl_wr && writedata[1];
    start_cmd   = ctrl_wr && writedata[0] && !writedata[1];
    win_wr_ok   = chipselect && write && (state != ARMED) && (state != CAPTURE);
    frame_start = !vsync_q && VSYNC;
    frame_end   = vsync_q && !VSYNC;
    x_hi        = {1'b0, win_x0} + {1'b0, win_w};
    y_hi        = {1'b0, win_y0} + {1'b0, win_h};
    x_in        = ({1'b0, x_cnt} >= {1'b0, win_x0}) && ({1'b0, x_cnt} < x_hi);
    y_in        = ({1'b0, y_cnt} >= {1'b0, win_y0}) && ({1'b0, y_cnt} < y_hi);
    in_win      = pix_en && x_in && y_in;
    capturing   = (state == CAPTURE) && in_win && !abort_cmd;
    pop         = chipselect && read && (address == ADDR_DATA) && (level != '0);
    fifo_full   = (level == LW'(FIFO_DEPTH));
    push        = capturing && (!fifo_full || pop);
    flush       = abort_cmd || (start_cmd && ((state == IDLE) || (state == DONE)));
    cap_target  = CW'(win_w) * CW'(win_h);
    last_pix    = ((cap_cnt + CW'(1)) == cap_target);
  end

  // Raster position tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      hsync_q <= HSYNC;
      vsync_q <= VSYNC;
      if (!HSYNC)
        x_cnt <= '0;
      else if (pix_en)
        x_cnt <= x_cnt + XW'(1);
      if (!VSYNC)
        y_cnt <= '0;
      else if (hsync_q && !HSYNC)
        y_cnt <= y_cnt + YW'(1);
    end
  end

  // Window geometry, frozen while a capture is pending
  always_ff @(posedge clk) begin
    if (reset) begin
      win_x0 <= '0;
      win_w  <= '0;
      win_y0 <= '0;
      win_h  <= '0;
    end else if (win_wr_ok) begin
      if (address == ADDR_WIN_X) begin
        win_x0 <= writedata[XW-1:0];
        win_w  <= writedata[16 +: XW];
      end else if (address == ADDR_WIN_Y) begin
        win_y0 <= writedata[YW-1:0];
        win_h  <= writedata[16 +: YW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {VGA_R, VGA_G, VGA_B};
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        level <= level + LW'(1);
      else if (pop && !push)
        level <= level - LW'(1);
    end
  end

  // Capture sequencer; busy is updated alongside every state change
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      overflow <= 1'b0;
      cap_cnt  <= '0;
      busy     <= 1'b0;
    end else if (abort_cmd) begin
      state <= IDLE;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_cmd) begin
            overflow <= 1'b0;
            cap_cnt  <= '0;
            if ((win_w == '0) || (win_h == '0)) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= ARMED;
              done  <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end
        ARMED: begin
          if (frame_start)
            state <= CAPTURE;
        end
        CAPTURE: begin
          if (in_win) begin
            cap_cnt <= cap_cnt + CW'(1);
            if (!push)
              overflow <= 1'b1;
          end
          if ((in_win && last_pix) || frame_end) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign irq = done;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL, ADDR_STATUS: begin
        readdata[0]      = busy;
        readdata[1]      = done;
        readdata[2]      = overflow;
        readdata[8 +: 16] = 16'(level);
      end
      ADDR_WIN_X: begin
        readdata[XW-1:0]  = win_x0;
        readdata[16 +: XW] = win_w;
      end
      ADDR_WIN_Y: begin
        readdata[YW-1:0]  = win_y0;
        readdata[16 +: YW] = win_h;
      end
      ADDR_DATA: begin
        if (level != '0)
          readdata = {mem[rd_ptr], 8'h00};
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_vga_capture_ctrl.sv
// Bench for vga_capture_ctrl: drives synthetic rasters into two instances (deep and
// 4-entry FIFO) and compares register reads against a queue-based window model.
module tb_vga_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs0 = 1'b0, cs1 = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [7:0]  addr = 8'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata0, rdata1;
  logic [7:0]  vr = 8'd0, vg = 8'd0, vb = 8'd0;
  logic        hs = 1'b1, vs = 1'b1, pe = 1'b0;
  logic        busy0, busy1, irq0, irq1;

  int total = 0;
  int bad   = 0;

  logic [23:0] mq [$];
  bit          movf;

  always #5 clk = ~clk;

  vga_capture_ctrl dut0 (
    .clk(clk), .reset(reset), .chipselect(cs0), .read(rd), .write(wr),
    .address(addr), .writedata(wdata), .readdata(rdata0),
    .VGA_R(vr), .VGA_G(vg), .VGA_B(vb), .HSYNC(hs), .VSYNC(vs), .pix_en(pe),
    .busy(busy0), .irq(irq0)
  );

  vga_capture_ctrl #(.FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .chipselect(cs1), .read(rd), .write(wr),
    .address(addr), .writedata(wdata), .readdata(rdata1),
    .VGA_R(vr), .VGA_G(vg), .VGA_B(vb), .HSYNC(hs), .VSYNC(vs), .pix_en(pe),
    .busy(busy1), .irq(irq1)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_word(input bit b, input bit d, input bit o, input int lvl);
    return {8'h00, 16'(lvl), 5'b0, o, d, b};
  endfunction

  task automatic sel(input int s);
    cs0 = (s == 0);
    cs1 = (s == 1);
  endtask

  task automatic bus_clear();
    cs0 = 1'b0; cs1 = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_write(input int s, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    sel(s); wr = 1'b1; rd = 1'b0; addr = a; wdata = d;
    @(posedge clk);
    #1;
    bus_clear();
  endtask

  task automatic bus_read(input int s, input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    sel(s); rd = 1'b1; wr = 1'b0; addr = a;
    #1;
    d = (s == 1) ? rdata1 : rdata0;
    @(posedge clk);
    #1;
    bus_clear();
  endtask

  task automatic drain(input int s, input string tag);
    logic [31:0] d, e;
    while (mq.size() > 0) begin
      e = {mq.pop_front(), 8'h00};
      bus_read(s, 8'd4, d);
      check(tag, d, e);
    end
  endtask

  // One frame: VSYNC pulse, then lines of pixels each followed by an HSYNC pulse, then
  // VSYNC falls. The model keeps the pixels that land in the window, in raster order.
  task automatic run_frame(input int s, input int lines, input int ppl, input bit rnd,
                           input int x0, input int w, input int y0, input int h,
                           input int pop_at, input int stop_after);
    int depth = (s == 1) ? 4 : 64;
    int k = 0;
    logic [23:0] px;
    logic [31:0] d;
    movf = 1'b0;
    @(negedge clk); bus_clear(); pe = 1'b0; hs = 1'b1; vs = 1'b0;
    @(negedge clk);
    @(negedge clk); vs = 1'b1;
    @(negedge clk);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < ppl; p++) begin
        if (rnd) begin
          repeat ($urandom_range(0, 2)) begin
            @(negedge clk); bus_clear(); pe = 1'b0;
          end
        end
        @(negedge clk);
        bus_clear();
        px = rnd ? 24'($urandom) : 24'(l * 16 + p);
        {vr, vg, vb} = px;
        pe = 1'b1;
        if (p >= x0 && p < x0 + w && l >= y0 && l < y0 + h && k < w * h) begin
          if (k == pop_at && mq.size() > 0) begin
            sel(s); rd = 1'b1; addr = 8'd4;
            #1;
            d = (s == 1) ? rdata1 : rdata0;
            check("pop_with_push", d, {mq.pop_front(), 8'h00});
          end
          if (mq.size() < depth) mq.push_back(px);
          else movf = 1'b1;
          k++;
          if (k == stop_after) begin
            @(negedge clk); bus_clear(); pe = 1'b0;
            return;
          end
        end
      end
      @(negedge clk); bus_clear(); pe = 1'b0; hs = 1'b0;
      @(negedge clk);
      @(negedge clk); hs = 1'b1;
    end
    @(negedge clk); vs = 1'b0;
    @(negedge clk);
    @(negedge clk); vs = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    int x0, w, y0, h, s;

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    bus_read(0, 8'd1, d);  check("rst_status", d, 32'h0);
    bus_read(0, 8'd4, d);  check("rst_data", d, 32'h0);
    bus_read(1, 8'd0, d);  check("rst_status_d4", d, 32'h0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_irq", 32'(irq0), 32'd0);

    // Basic 3x2 window in an 8x4 raster
    bus_write(0, 8'd2, (32'd3 << 16) | 32'd2);
    bus_write(0, 8'd3, (32'd2 << 16) | 32'd1);
    bus_read(0, 8'd2, d);  check("win_x_rb", d, 32'h0003_0002);
    bus_write(0, 8'd0, 32'd1);
    check("armed_busy", 32'(busy0), 32'd1);
    bus_write(0, 8'd2, 32'h0007_0005);
    bus_read(0, 8'd2, d);  check("win_locked", d, 32'h0003_0002);
    run_frame(0, 4, 8, 1'b0, 2, 3, 1, 2, -1, -1);
    bus_read(0, 8'd1, d);  check("basic_status", d, status_word(0, 1, movf, mq.size()));
    check("basic_irq", 32'(irq0), 32'd1);
    drain(0, "basic_data");
    bus_read(0, 8'd1, d);  check("basic_empty", d, status_word(0, 1, 0, 0));
    bus_read(0, 8'd4, d);  check("empty_data", d, 32'h0);

    // Same window into a 4-entry FIFO with no reads: overflow
    bus_write(1, 8'd2, (32'd3 << 16) | 32'd2);
    bus_write(1, 8'd3, (32'd2 << 16) | 32'd1);
    bus_write(1, 8'd0, 32'd1);
    run_frame(1, 4, 8, 1'b0, 2, 3, 1, 2, -1, -1);
    bus_read(1, 8'd1, d);  check("ovf_status", d, status_word(0, 1, movf, mq.size()));
    check("ovf_irq", 32'(irq1), 32'd1);
    drain(1, "ovf_data");

    // Truncated frame: height 3, only two window lines before VSYNC falls
    bus_write(0, 8'd3, (32'd3 << 16) | 32'd1);
    bus_write(0, 8'd0, 32'd1);
    run_frame(0, 3, 8, 1'b0, 2, 3, 1, 3, -1, -1);
    bus_read(0, 8'd1, d);  check("trunc_status", d, status_word(0, 1, movf, mq.size()));
    drain(0, "trunc_data");

    // Zero width completes immediately
    bus_write(0, 8'd2, 32'd2);
    bus_write(0, 8'd0, 32'd1);
    check("w0_irq", 32'(irq0), 32'd1);
    check("w0_busy", 32'(busy0), 32'd0);
    bus_read(0, 8'd1, d);  check("w0_status", d, status_word(0, 1, 0, 0));

    // Abort after two pushes
    bus_write(0, 8'd2, 32'd4 << 16);
    bus_write(0, 8'd3, 32'd2 << 16);
    bus_write(0, 8'd0, 32'd1);
    run_frame(0, 2, 8, 1'b0, 0, 4, 0, 2, -1, 2);
    bus_read(0, 8'd1, d);  check("pre_abort", d, status_word(1, 0, 0, mq.size()));
    bus_write(0, 8'd0, 32'd3);
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_irq", 32'(irq0), 32'd0);
    bus_read(0, 8'd1, d);  check("abort_status", d, 32'h0);
    mq.delete();
    @(negedge clk); hs = 1'b0;
    @(negedge clk); hs = 1'b1;

    // Push and pop on the same cycle at a full 4-entry FIFO
    bus_write(1, 8'd2, 32'd5 << 16);
    bus_write(1, 8'd3, 32'd1 << 16);
    bus_write(1, 8'd0, 32'd1);
    run_frame(1, 1, 8, 1'b0, 0, 5, 0, 1, 4, -1);
    bus_read(1, 8'd1, d);  check("pp_status", d, status_word(0, 1, movf, mq.size()));
    drain(1, "pp_data");

    // Randomized windows and pixel values, alternating FIFO depths
    for (int it = 0; it < 6; it++) begin
      s  = it % 2;
      x0 = $urandom_range(0, 6);
      w  = $urandom_range(1, 4);
      y0 = $urandom_range(0, 3);
      h  = $urandom_range(1, 3);
      bus_write(s, 8'd2, (32'(w) << 16) | 32'(x0));
      bus_write(s, 8'd3, (32'(h) << 16) | 32'(y0));
      bus_write(s, 8'd0, 32'd1);
      run_frame(s, 6, 10, 1'b1, x0, w, y0, h, -1, -1);
      bus_read(s, 8'd1, d);  check("rand_status", d, status_word(0, 1, movf, mq.size()));
      drain(s, "rand_data");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
